// File: rtl/serial_link_pkg.sv
// Shared types for the serial link PHY: per-channel TX config and FSM state.
// Field widths are upper bounds; narrower top-level config ports are zero-extended.
package serial_link_pkg;

  localparam int unsigned PhyTxCntW  = 8;
  localparam int unsigned PhyTxTailW = 8;

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Run  = 2'd1,
    Tail = 2'd2
  } phy_tx_state_e;

  typedef struct packed {
    logic [PhyTxCntW-1:0]  clk_div;
    logic [PhyTxCntW-1:0]  shift_start;
    logic [PhyTxCntW-1:0]  shift_end;
    logic                  ddr_en;
    logic [PhyTxTailW-1:0] tail;
  } phy_tx_cfg_t;

  // A beat period shorter than two cycles cannot hold both clock edges.
  function automatic logic [PhyTxCntW-1:0] phy_tx_sanitize_div(input logic [PhyTxCntW-1:0] div);
    return (div < PhyTxCntW'(2)) ? PhyTxCntW'(2) : div;
  endfunction

endpackage

// File: rtl/serial_link_phy_tx_chan.sv
// One TX channel: handshake, period counter, beat register, lane mux and
// forwarded-clock toggle flop, with an optional clock tail after the last beat.
module serial_link_phy_tx_chan
  import serial_link_pkg::*;
#(
  parameter int unsigned NumLanes = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  phy_tx_cfg_t           cfg_i,
  input  logic                  en_i,
  input  logic [2*NumLanes-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  phy_clk_o,
  output logic [NumLanes-1:0]   phy_data_o,
  output logic                  busy_o
);

  phy_tx_state_e         state_q, state_d;
  phy_tx_cfg_t           cfg_q, cfg_d;
  logic [PhyTxCntW-1:0]  cnt_q, cnt_d;
  logic [PhyTxTailW-1:0] tail_cnt_q, tail_cnt_d;
  logic [2*NumLanes-1:0] beat_q, beat_d;
  logic                  clk_q, clk_d;
  logic [NumLanes-1:0]   data_q, data_d;

  logic period_end;
  logic accept;
  logic shift_hit;
  logic high_half;

  assign period_end = (state_q != Idle) && (cnt_q == (cfg_q.clk_div - PhyTxCntW'(1)));
  // Ready is forced low while reset is asserted so nothing is accepted into a held FSM.
  assign ready_o    = rst_ni & en_i & ((state_q == Idle) | period_end);
  assign accept     = valid_i & ready_o;
  assign shift_hit  = (cnt_q == cfg_q.shift_start) | (cnt_q == cfg_q.shift_end);

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    cnt_d      = cnt_q;
    tail_cnt_d = tail_cnt_q;
    beat_d     = beat_q;
    if (accept) begin
      beat_d = data_i;
    end

    unique case (state_q)
      Idle: begin
        cnt_d = '0;
        if (accept) begin
          state_d       = Run;
          cfg_d         = cfg_i;
          cfg_d.clk_div = phy_tx_sanitize_div(cfg_i.clk_div);
        end
      end
      Run, Tail: begin
        cnt_d = period_end ? '0 : cnt_q + PhyTxCntW'(1);
        if (period_end) begin
          if (accept) begin
            state_d = Run;
          end else if (state_q == Run) begin
            if (cfg_q.tail == '0) begin
              state_d = Idle;
            end else begin
              state_d    = Tail;
              tail_cnt_d = cfg_q.tail;
            end
          end else begin
            tail_cnt_d = tail_cnt_q - PhyTxTailW'(1);
            if (tail_cnt_q == PhyTxTailW'(1)) begin
              state_d = Idle;
            end
          end
        end
      end
      default: begin
        state_d = Idle;
        cnt_d   = '0;
      end
    endcase
  end

  // Lane/clock outputs are computed from next-cycle state so the registered
  // lanes line up with the counter value they belong to.
  always_comb begin
    clk_d     = clk_q;
    data_d    = '0;
    high_half = cfg_d.ddr_en && (cnt_d >= (cfg_d.clk_div >> 1));
    if ((state_q == Idle) || (state_d == Idle)) begin
      clk_d = 1'b1;
    end else if (shift_hit) begin
      clk_d = ~clk_q;
    end
    if (state_d == Run) begin
      data_d = high_half ? beat_d[2*NumLanes-1:NumLanes] : beat_d[NumLanes-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= Idle;
      cfg_q      <= '0;
      cnt_q      <= '0;
      tail_cnt_q <= '0;
      beat_q     <= '0;
      clk_q      <= 1'b1;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      cnt_q      <= cnt_d;
      tail_cnt_q <= tail_cnt_d;
      beat_q     <= beat_d;
      clk_q      <= clk_d;
      data_q     <= data_d;
    end
  end

  assign phy_clk_o  = clk_q;
  assign phy_data_o = data_q;
  assign busy_o     = (state_q != Idle);

endmodule

// File: rtl/serial_link_phy_tx_mc.sv
// Multi-channel source-synchronous TX PHY: independent channels sharing one
// runtime configuration, each forwarding its own clock alongside its lanes.
module serial_link_phy_tx_mc
  import serial_link_pkg::*;
#(
  parameter  int unsigned NumChannels = 1,
  parameter  int unsigned NumLanes    = 8,
  parameter  int unsigned MaxClkDiv   = 32,
  parameter  int unsigned TailW       = 4,
  localparam int unsigned CW          = $clog2(MaxClkDiv) + 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [CW-1:0]                   cfg_clk_div_i,
  input  logic [CW-1:0]                   cfg_shift_start_i,
  input  logic [CW-1:0]                   cfg_shift_end_i,
  input  logic                            cfg_ddr_en_i,
  input  logic [TailW-1:0]                cfg_tail_i,
  input  logic [NumChannels-1:0]          chan_en_i,
  input  logic [NumChannels*2*NumLanes-1:0] data_i,
  input  logic [NumChannels-1:0]          valid_i,
  output logic [NumChannels-1:0]          ready_o,
  output logic [NumChannels-1:0]          phy_clk_o,
  output logic [NumChannels*NumLanes-1:0] phy_data_o,
  output logic [NumChannels-1:0]          busy_o
);

  phy_tx_cfg_t cfg;

  // CW and TailW must not exceed the package field widths.
  assign cfg.clk_div     = PhyTxCntW'(cfg_clk_div_i);
  assign cfg.shift_start = PhyTxCntW'(cfg_shift_start_i);
  assign cfg.shift_end   = PhyTxCntW'(cfg_shift_end_i);
  assign cfg.ddr_en      = cfg_ddr_en_i;
  assign cfg.tail        = PhyTxTailW'(cfg_tail_i);

  for (genvar gi = 0; gi < NumChannels; gi++) begin : g_chan
    serial_link_phy_tx_chan #(
      .NumLanes (NumLanes)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .cfg_i      (cfg),
      .en_i       (chan_en_i[gi]),
      .data_i     (data_i[gi*2*NumLanes +: 2*NumLanes]),
      .valid_i    (valid_i[gi]),
      .ready_o    (ready_o[gi]),
      .phy_clk_o  (phy_clk_o[gi]),
      .phy_data_o (phy_data_o[gi*NumLanes +: NumLanes]),
      .busy_o     (busy_o[gi])
    );
  end

endmodule

// File: tb/tb_serial_link_phy_tx_mc.sv
// Bench for serial_link_phy_tx_mc: directed vector table, corner sequences and
// randomized traffic, all checked against a burst-position reference model.
module tb_serial_link_phy_tx_mc;
  localparam int NCH = 2;
  localparam int NL  = 8;
  localparam int CW  = 6;
  localparam int TW  = 4;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b1;
  logic [CW-1:0]       cfg_clk_div_i = '0;
  logic [CW-1:0]       cfg_shift_start_i = '0;
  logic [CW-1:0]       cfg_shift_end_i = '0;
  logic                cfg_ddr_en_i = 1'b0;
  logic [TW-1:0]       cfg_tail_i = '0;
  logic [NCH-1:0]      chan_en_i = '0;
  logic [NCH*2*NL-1:0] data_i = '0;
  logic [NCH-1:0]      valid_i = '0;
  logic [NCH-1:0]      ready_o;
  logic [NCH-1:0]      phy_clk_o;
  logic [NCH*NL-1:0]   phy_data_o;
  logic [NCH-1:0]      busy_o;

  always #5 clk_i = ~clk_i;

  serial_link_phy_tx_mc #(
    .NumChannels (NCH),
    .NumLanes    (NL),
    .MaxClkDiv   (32),
    .TailW       (TW)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .cfg_clk_div_i     (cfg_clk_div_i),
    .cfg_shift_start_i (cfg_shift_start_i),
    .cfg_shift_end_i   (cfg_shift_end_i),
    .cfg_ddr_en_i      (cfg_ddr_en_i),
    .cfg_tail_i        (cfg_tail_i),
    .chan_en_i         (chan_en_i),
    .data_i            (data_i),
    .valid_i           (valid_i),
    .ready_o           (ready_o),
    .phy_clk_o         (phy_clk_o),
    .phy_data_o        (phy_data_o),
    .busy_o            (busy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a burst is a run of positions p from its start; the beat
  // occupying period p/div is the latest accepted one, later periods are tail.
  bit          m_act [NCH];
  int          m_p   [NCH];
  int          m_div [NCH];
  int          m_s   [NCH];
  int          m_e   [NCH];
  int          m_tail[NCH];
  int          m_last[NCH];
  bit          m_ddr [NCH];
  logic [15:0] m_beat[NCH];

  task automatic model_out(input int c, output logic oclk, output logic [NL-1:0] odat,
                           output logic obusy, output logic ordy);
    int k, ph, m, part;
    if (!m_act[c]) begin
      oclk = 1'b1; odat = '0; obusy = 1'b0; ordy = chan_en_i[c];
    end else begin
      k  = m_p[c] / m_div[c];
      ph = m_p[c] % m_div[c];
      m    = int'(m_s[c] < m_div[c]) + int'((m_e[c] < m_div[c]) && (m_e[c] != m_s[c]));
      part = int'(m_s[c] < ph) + int'((m_e[c] < ph) && (m_e[c] != m_s[c]));
      oclk  = (((k * m + part) % 2) == 0);
      obusy = 1'b1;
      ordy  = chan_en_i[c] && (ph == m_div[c] - 1);
      if (k != m_last[c])                        odat = '0;
      else if (m_ddr[c] && ph >= m_div[c] / 2)   odat = m_beat[c][15:8];
      else                                       odat = m_beat[c][7:0];
    end
  endtask

  task automatic model_advance(input int c);
    logic oc, ob, orr;
    logic [NL-1:0] od;
    bit acc;
    model_out(c, oc, od, ob, orr);
    acc = valid_i[c] && orr;
    if (!m_act[c]) begin
      if (acc) begin
        m_act[c]  = 1;
        m_p[c]    = 0;
        m_div[c]  = (int'(cfg_clk_div_i) < 2) ? 2 : int'(cfg_clk_div_i);
        m_s[c]    = int'(cfg_shift_start_i);
        m_e[c]    = int'(cfg_shift_end_i);
        m_ddr[c]  = cfg_ddr_en_i;
        m_tail[c] = int'(cfg_tail_i);
        m_last[c] = 0;
        m_beat[c] = data_i[c*16 +: 16];
      end
    end else begin
      if (acc) begin
        m_last[c] = m_p[c] / m_div[c] + 1;
        m_beat[c] = data_i[c*16 +: 16];
      end
      m_p[c]++;
      if (m_p[c] >= (m_last[c] + m_tail[c] + 1) * m_div[c]) m_act[c] = 0;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    logic oc, ob, orr;
    logic [NL-1:0] od;
    #1;
    for (int c = 0; c < NCH; c++) begin
      model_out(c, oc, od, ob, orr);
      chk($sformatf("clk ch%0d", c), phy_clk_o[c], oc);
      chk($sformatf("data ch%0d", c), phy_data_o[c*NL +: NL], od);
      chk($sformatf("busy ch%0d", c), busy_o[c], ob);
      chk($sformatf("ready ch%0d", c), ready_o[c], orr);
    end
    for (int c = 0; c < NCH; c++) model_advance(c);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    chk("rst clk", phy_clk_o, {NCH{1'b1}});
    chk("rst data", phy_data_o, '0);
    chk("rst busy", busy_o, '0);
    chk("rst ready", ready_o, '0);
    for (int c = 0; c < NCH; c++) m_act[c] = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic set_cfg(input logic ddr, input int div, input int s, input int e, input int tl);
    cfg_ddr_en_i      = ddr;
    cfg_clk_div_i     = CW'(div);
    cfg_shift_start_i = CW'(s);
    cfg_shift_end_i   = CW'(e);
    cfg_tail_i        = TW'(tl);
  endtask

  // Single beat on channel 0, then count cycles with busy high.
  task automatic burst_len(input logic [15:0] d, output int n);
    valid_i[0] = 1'b1;
    data_i[15:0] = d;
    step();
    valid_i[0] = 1'b0;
    n = 0;
    while (busy_o[0] && n < 200) begin
      step();
      n++;
    end
  endtask

  typedef struct packed {
    logic        ddr;
    logic [5:0]  div;
    logic [5:0]  s;
    logic [5:0]  e;
    logic [3:0]  tail;
    logic        v;
    logic [15:0] d;
    logic        eclk;
    logic [7:0]  edat;
    logic        ebusy;
    logic        erdy;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // DDR div4, edges at 1/3, single beat
    tbl[0]  = '{1'b1, 6'd4, 6'd1, 6'd3, 4'd0, 1'b1, 16'hA55A, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 6'd4, 6'd1, 6'd3, 4'd0, 1'b0, 16'h0000, 1'b1, 8'h5A, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 6'd4, 6'd1, 6'd3, 4'd0, 1'b0, 16'h0000, 1'b1, 8'h5A, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 6'd4, 6'd1, 6'd3, 4'd0, 1'b0, 16'h0000, 1'b0, 8'hA5, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 6'd4, 6'd1, 6'd3, 4'd0, 1'b0, 16'h0000, 1'b0, 8'hA5, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 6'd4, 6'd1, 6'd3, 4'd0, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b1};
    // SDR div2, edges at 0/1, four back-to-back beats (high byte ignored)
    tbl[6]  = '{1'b0, 6'd2, 6'd0, 6'd1, 4'd0, 1'b1, 16'hF011, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 6'd2, 6'd0, 6'd1, 4'd0, 1'b1, 16'hE022, 1'b1, 8'h11, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 6'd2, 6'd0, 6'd1, 4'd0, 1'b1, 16'hE022, 1'b0, 8'h11, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 6'd2, 6'd0, 6'd1, 4'd0, 1'b1, 16'hD033, 1'b1, 8'h22, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 6'd2, 6'd0, 6'd1, 4'd0, 1'b1, 16'hD033, 1'b0, 8'h22, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 6'd2, 6'd0, 6'd1, 4'd0, 1'b1, 16'hC044, 1'b1, 8'h33, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 6'd2, 6'd0, 6'd1, 4'd0, 1'b1, 16'hC044, 1'b0, 8'h33, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 6'd2, 6'd0, 6'd1, 4'd0, 1'b0, 16'h0000, 1'b1, 8'h44, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 6'd2, 6'd0, 6'd1, 4'd0, 1'b0, 16'h0000, 1'b0, 8'h44, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 6'd2, 6'd0, 6'd1, 4'd0, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b1};

    @(negedge clk_i);
    do_reset();

    chan_en_i = 2'b01;
    for (int i = 0; i < 16; i++) begin
      set_cfg(tbl[i].ddr, int'(tbl[i].div), int'(tbl[i].s), int'(tbl[i].e), int'(tbl[i].tail));
      valid_i[0]   = tbl[i].v;
      data_i[15:0] = tbl[i].d;
      #1;
      chk($sformatf("vec%0d clk", i), phy_clk_o[0], tbl[i].eclk);
      chk($sformatf("vec%0d data", i), phy_data_o[7:0], tbl[i].edat);
      chk($sformatf("vec%0d busy", i), busy_o[0], tbl[i].ebusy);
      chk($sformatf("vec%0d ready", i), ready_o[0], tbl[i].erdy);
      step();
    end

    // Tail of 3 periods after a single div-4 beat
    set_cfg(1'b1, 4, 1, 3, 3);
    burst_len(16'h0F0F, n);
    chk("tail busy len", n, 16);

    // New beat at the end of tail period 2 resumes RUN
    valid_i[0] = 1'b1; data_i[15:0] = 16'h1234;
    step();
    valid_i[0] = 1'b0;
    for (int i = 0; i < 11; i++) step();
    valid_i[0] = 1'b1; data_i[15:0] = 16'hBEEF;
    #1;
    chk("tail resume ready", ready_o[0], 1);
    step();
    valid_i[0] = 1'b0;
    #1;
    chk("tail resume data", phy_data_o[7:0], 8'hEF);
    chk("tail resume clk", phy_clk_o[0], 1);
    n = 0;
    while (busy_o[0] && n < 200) begin step(); n++; end
    chk("tail resume len", n, 16);

    // Divider change mid-burst takes effect only on the next burst
    set_cfg(1'b0, 4, 0, 2, 0);
    valid_i[0] = 1'b1; data_i[15:0] = 16'h0101;
    step();
    cfg_clk_div_i = CW'(8);
    n = 0;
    for (int i = 0; i < 8; i++) begin step(); n++; end
    valid_i[0] = 1'b0;
    while (busy_o[0] && n < 200) begin step(); n++; end
    chk("div change len", n, 12);
    burst_len(16'h0077, n);
    chk("div8 len", n, 8);
    cfg_clk_div_i = CW'(1);
    burst_len(16'h0066, n);
    chk("div1 len", n, 2);

    // Two channels offset in time, then reset mid-beat
    set_cfg(1'b1, 4, 1, 3, 2);
    chan_en_i = 2'b11;
    valid_i = 2'b01; data_i = 32'h2222_1111;
    step();
    valid_i = 2'b00; step(); step();
    valid_i = 2'b10; step();
    valid_i = 2'b00; step(); step();
    chk("indep busy", busy_o, 2'b11);
    #2;
    do_reset();
    step(); step();

    // Randomized traffic
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ((cyc % 37) == 0)
        set_cfg(1'($urandom_range(0, 1)), $urandom_range(0, 9), $urandom_range(0, 10),
                $urandom_range(0, 10), $urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) chan_en_i = 2'($urandom_range(0, 3));
      else if ($urandom_range(0, 19) == 0) chan_en_i = 2'b11;
      for (int c = 0; c < NCH; c++) begin
        valid_i[c] = ($urandom_range(0, 3) != 0);
        data_i[c*16 +: 16] = 16'($urandom);
      end
      if ($urandom_range(0, 399) == 0) begin
        #2;
        do_reset();
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
